rx_audio_framer: RTL and testbench

RX_AUDIO_FRAMER -- requirements
Module: rx_audio_framer

---
 rtl/rx_audio_framer.sv | 192 +++++++++++++++++++
 tb/tb_rx_audio_framer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/rx_audio_framer.sv
// Packs each DDC sample set into a circular buffer as channel words, then closes the
// frame with a timestamp trailer and a frame counter; frames that would not fit are dropped.
module rx_audio_framer #(
  parameter int NCH = 8,
  parameter int WPC = 3,
  parameter int AW  = 13,
  parameter int TSW = 3
) (
  input  logic                  adc_clk,
  input  logic                  reset_A,
  input  logic [7:0]            nrx_samps,
  input  logic [NCH-1:0]        ch_en,
  input  logic                  rx_avail_A,
  input  logic [NCH*WPC*16-1:0] rxn_din_A,
  input  logic [47:0]           ticks_A,
  input  logic [AW-1:0]         raddr_A,
  output logic                  wr_A,
  output logic [AW-1:0]         waddr_A,
  output logic [15:0]           wdata_A,
  output logic                  frame_done_A,
  output logic [15:0]           buf_ctr_A,
  output logic [7:0]            drop_cnt_A,
  output logic [7:0]            ovr_cnt_A,
  output logic                  busy_A
);
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int WW  = (WPC > 1) ? $clog2(WPC) : 1;
  localparam int NW  = NCH * WPC;
  localparam int IW  = (NW > 1) ? $clog2(NW) : 1;

  typedef enum logic [2:0] {IDLE, CHAN, TS, CTR, DONE, SKIPWAIT} state_t;
  state_t state_reg, state_next;

  logic [7:0]            count_reg, n_reg, skip_reg;
  logic [NCH-1:0]        mask_reg, rem_reg;
  logic [47:0]           ticks_reg;
  logic [NCH*WPC*16-1:0] din_reg;
  logic [WW-1:0]         w_reg;
  logic [1:0]            ts_reg;
  logic [AW-1:0]         waddr_reg;
  logic [15:0]           buf_ctr_reg;
  logic [7:0]            drop_reg, ovr_reg;

  logic [7:0]     n_eff;
  logic [4:0]     pop;
  logic [31:0]    frame_words, free_words;
  logic [AW-1:0]  used;
  logic           accept, start, drop;
  logic [CHW-1:0] cur_ch;
  logic [NCH-1:0] rem_clr;
  logic           last_word, chan_end, last_sample, ts_last;
  logic [IW-1:0]  word_idx;
  logic [15:0]    word_arr [NW];

  genvar gi;
  generate
    for (gi = 0; gi < NW; gi++) begin : g_words
      assign word_arr[gi] = din_reg[gi*16 +: 16];
    end
  endgenerate

  assign n_eff  = (nrx_samps == 8'd0) ? 8'd1 : nrx_samps;
  assign accept = (state_reg == IDLE) && rx_avail_A;
  assign start  = accept && (count_reg == 8'd0);
  assign used   = waddr_reg - raddr_A;

  // Whole-frame space check, done once so a frame is never left half-written.
  assign frame_words = 32'(n_eff) * 32'(WPC) * 32'(pop) + 32'(TSW) + 32'd1;
  assign free_words  = (32'd1 << AW) - 32'd1 - 32'(used);
  assign drop        = start && (frame_words > free_words);

  always_comb begin
    pop = '0;
    for (int i = 0; i < NCH; i++) pop = pop + 5'(ch_en[i]);
  end

  // rem_reg holds channels still to be written; the lowest set bit is the current one.
  always_comb begin
    cur_ch = '0;
    for (int i = NCH - 1; i >= 0; i--) if (rem_reg[i]) cur_ch = CHW'(i);
  end

  assign rem_clr     = rem_reg & (rem_reg - NCH'(1));
  assign last_word   = (w_reg == WW'(WPC - 1));
  assign chan_end    = (rem_reg == '0) || (last_word && rem_clr == '0);
  assign last_sample = ({1'b0, count_reg} + 9'd1) >= {1'b0, n_reg};
  assign ts_last     = (ts_reg == 2'(TSW - 1));
  assign word_idx    = IW'(int'(cur_ch) * WPC + int'(w_reg));

  always_ff @(posedge adc_clk or posedge reset_A) begin
    if (reset_A) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:     if (rx_avail_A) state_next = drop ? SKIPWAIT : CHAN;
      CHAN:     if (chan_end) state_next = !last_sample ? IDLE : ((TSW == 0) ? CTR : TS);
      TS:       if (ts_last) state_next = CTR;
      CTR:      state_next = DONE;
      DONE:     state_next = IDLE;
      SKIPWAIT: if (skip_reg == 8'd0 || (rx_avail_A && skip_reg == 8'd1)) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge adc_clk or posedge reset_A) begin
    if (reset_A) begin
      count_reg   <= '0;
      n_reg       <= 8'd1;
      skip_reg    <= '0;
      mask_reg    <= '0;
      rem_reg     <= '0;
      ticks_reg   <= '0;
      din_reg     <= '0;
      w_reg       <= '0;
      ts_reg      <= '0;
      waddr_reg   <= '0;
      buf_ctr_reg <= '0;
      drop_reg    <= '0;
      ovr_reg     <= '0;
    end else begin
      if (wr_A) waddr_reg <= waddr_reg + AW'(1);
      if (busy_A && rx_avail_A && ovr_reg != 8'hFF) ovr_reg <= ovr_reg + 8'd1;
      case (state_reg)
        IDLE: if (rx_avail_A) begin
          din_reg <= rxn_din_A;
          w_reg   <= '0;
          rem_reg <= start ? ch_en : mask_reg;
          if (start) begin
            mask_reg  <= ch_en;
            n_reg     <= n_eff;
            ticks_reg <= ticks_A;
            skip_reg  <= n_eff - 8'd1;
          end
          if (drop && drop_reg != 8'hFF) drop_reg <= drop_reg + 8'd1;
        end
        CHAN: begin
          if (rem_reg != '0) begin
            if (last_word) begin
              w_reg   <= '0;
              rem_reg <= rem_clr;
            end else begin
              w_reg <= w_reg + WW'(1);
            end
          end
          if (chan_end && !last_sample) count_reg <= count_reg + 8'd1;
          ts_reg <= '0;
        end
        TS:   ts_reg <= ts_reg + 2'd1;
        DONE: begin
          buf_ctr_reg <= buf_ctr_reg + 16'd1;
          count_reg   <= '0;
        end
        SKIPWAIT: if (rx_avail_A && skip_reg != 8'd0) skip_reg <= skip_reg - 8'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    wr_A    = 1'b0;
    wdata_A = '0;
    case (state_reg)
      CHAN: if (rem_reg != '0) begin
        wr_A    = 1'b1;
        wdata_A = word_arr[word_idx];
      end
      TS: begin
        wr_A = 1'b1;
        case (ts_reg)
          2'd0:    wdata_A = ticks_reg[15:0];
          2'd1:    wdata_A = ticks_reg[31:16];
          default: wdata_A = ticks_reg[47:32];
        endcase
      end
      CTR: begin
        wr_A    = 1'b1;
        wdata_A = buf_ctr_reg + 16'd1;
      end
      default: ;
    endcase
  end

  assign frame_done_A = (state_reg == DONE);
  assign busy_A       = (state_reg != IDLE) && (state_reg != SKIPWAIT);
  assign waddr_A      = waddr_reg;
  assign buf_ctr_A    = buf_ctr_reg;
  assign drop_cnt_A   = drop_reg;
  assign ovr_cnt_A    = ovr_reg;
endmodule

// File: tb/tb_rx_audio_framer.sv
// Directed bench for rx_audio_framer on a small 32-word buffer: frame layout, mask/ticks
// latching, drop and skip, overrun, mid-frame reset and address wrap.
module tb_rx_audio_framer;
  localparam int NCH   = 4;
  localparam int WPC   = 3;
  localparam int AW    = 5;
  localparam int TSW   = 3;
  localparam int DEPTH = 1 << AW;

  logic                  adc_clk;
  logic                  reset_A;
  logic [7:0]            nrx_samps;
  logic [NCH-1:0]        ch_en;
  logic                  rx_avail_A;
  logic [NCH*WPC*16-1:0] rxn_din_A;
  logic [47:0]           ticks_A;
  logic [AW-1:0]         raddr_A;
  logic                  wr_A;
  logic [AW-1:0]         waddr_A;
  logic [15:0]           wdata_A;
  logic                  frame_done_A;
  logic [15:0]           buf_ctr_A;
  logic [7:0]            drop_cnt_A;
  logic [7:0]            ovr_cnt_A;
  logic                  busy_A;

  int errors = 0;
  int checks = 0;
  int log_n  = 0;
  int fd_cnt = 0;
  logic [15:0]   log_data [512];
  logic [AW-1:0] log_addr [512];
  logic [15:0]   exp_data [512];
  int exp_n, exp_waddr, exp_ctr, exp_drop, exp_ovr;
  int k, fd0;

  initial adc_clk = 1'b0;
  always #5 adc_clk = ~adc_clk;

  rx_audio_framer #(.NCH(NCH), .WPC(WPC), .AW(AW), .TSW(TSW)) dut (
    .adc_clk(adc_clk), .reset_A(reset_A), .nrx_samps(nrx_samps), .ch_en(ch_en),
    .rx_avail_A(rx_avail_A), .rxn_din_A(rxn_din_A), .ticks_A(ticks_A), .raddr_A(raddr_A),
    .wr_A(wr_A), .waddr_A(waddr_A), .wdata_A(wdata_A), .frame_done_A(frame_done_A),
    .buf_ctr_A(buf_ctr_A), .drop_cnt_A(drop_cnt_A), .ovr_cnt_A(ovr_cnt_A), .busy_A(busy_A)
  );

  always @(negedge adc_clk) begin
    if (wr_A && log_n < 512) begin
      log_data[log_n] <= wdata_A;
      log_addr[log_n] <= waddr_A;
      log_n <= log_n + 1;
    end
    if (frame_done_A) fd_cnt <= fd_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic logic [15:0] pat(input int tag, input int s, input int c, input int w);
    return {4'(tag), 4'(s), 4'(c), 4'(w)};
  endfunction

  function automatic int popc(input logic [NCH-1:0] m);
    int p = 0;
    for (int i = 0; i < NCH; i++) p += int'(m[i]);
    return p;
  endfunction

  task automatic load_din(input int tag, input int s);
    for (int c = 0; c < NCH; c++)
      for (int w = 0; w < WPC; w++)
        rxn_din_A[(c*WPC+w)*16 +: 16] = pat(tag, s, c, w);
  endtask

  // One accepted pulse; optionally a second pulse landing on the second CHAN cycle.
  task automatic pulse(input bit inject);
    @(negedge adc_clk); rx_avail_A = 1'b1;
    @(negedge adc_clk); rx_avail_A = 1'b0;
    if (inject) begin
      rxn_din_A = '1;
      @(negedge adc_clk); rx_avail_A = 1'b1;
      @(negedge adc_clk); rx_avail_A = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy_A && n < 200) begin
      @(negedge adc_clk);
      n++;
    end
    check("idle_timeout", 64'(busy_A), 64'd0);
  endtask

  // m0 is the mask at frame start, m1 is driven after the first sample; rd<0 means the
  // reader has caught up with the writer.
  task automatic do_frame(input int tag, input logic [NCH-1:0] m0, input logic [NCH-1:0] m1,
                          input int n, input logic [47:0] tk, input int rd, input int ovr_s);
    int neff, f, freew, start, base, fd_start;
    bit drop;
    neff     = (n == 0) ? 1 : n;
    raddr_A  = (rd < 0) ? AW'(exp_waddr) : AW'(rd);
    ch_en    = m0;
    nrx_samps = 8'(n);
    ticks_A  = tk;
    f        = neff * WPC * popc(m0) + TSW + 1;
    freew    = DEPTH - 1 - ((exp_waddr - int'(raddr_A)) & (DEPTH - 1));
    drop     = (f > freew);
    start    = log_n;
    fd_start = fd_cnt;
    base     = exp_waddr;
    exp_n    = 0;
    if (!drop) begin
      for (int s = 0; s < neff; s++)
        for (int c = 0; c < NCH; c++)
          if (m0[c])
            for (int w = 0; w < WPC; w++) begin
              exp_data[exp_n] = pat(tag, s, c, w);
              exp_n++;
            end
      for (int t = 0; t < TSW; t++) begin
        exp_data[exp_n] = tk[t*16 +: 16];
        exp_n++;
      end
      exp_ctr = (exp_ctr + 1) & 16'hFFFF;
      exp_data[exp_n] = 16'(exp_ctr);
      exp_n++;
      exp_waddr = (exp_waddr + exp_n) % DEPTH;
    end else begin
      exp_drop++;
    end
    for (int s = 0; s < neff; s++) begin
      load_din(tag, s);
      pulse(s == ovr_s);
      if (s == ovr_s) exp_ovr++;
      if (s == 0) begin
        ch_en     = m1;
        ticks_A   = ~tk;
        nrx_samps = 8'(n + 1);
      end
      wait_idle();
    end
    @(negedge adc_clk);
    @(negedge adc_clk);
    #1;
    check("nwrites", 64'(log_n - start), 64'(exp_n));
    for (int i = 0; i < exp_n && start + i < log_n; i++) begin
      check("wdata", 64'(log_data[start+i]), 64'(exp_data[i]));
      check("waddr", 64'(log_addr[start+i]), 64'((base + i) % DEPTH));
    end
    check("waddr_end", 64'(waddr_A), 64'(exp_waddr));
    check("buf_ctr", 64'(buf_ctr_A), 64'(exp_ctr));
    check("drop_cnt", 64'(drop_cnt_A), 64'(exp_drop));
    check("ovr_cnt", 64'(ovr_cnt_A), 64'(exp_ovr));
    check("frame_done", 64'(fd_cnt - fd_start), drop ? 64'd0 : 64'd1);
    $display("frame tag=%0h mask=%b n=%0d drop=%0d words=%0d waddr=%0d ctr=%0d",
             tag, m0, n, drop, log_n - start, waddr_A, buf_ctr_A);
  endtask

  initial begin
    reset_A = 1'b1; rx_avail_A = 1'b0; nrx_samps = 8'd1; ch_en = '0;
    rxn_din_A = '0; ticks_A = '0; raddr_A = '0;
    exp_waddr = 0; exp_ctr = 0; exp_drop = 0; exp_ovr = 0; exp_n = 0;
    repeat (3) @(negedge adc_clk);
    check("rst_wr", 64'(wr_A), 64'd0);
    check("rst_waddr", 64'(waddr_A), 64'd0);
    check("rst_busy", 64'(busy_A), 64'd0);
    check("rst_ctr", 64'(buf_ctr_A), 64'd0);
    check("rst_wdata", 64'(wdata_A), 64'd0);
    reset_A = 1'b0;

    do_frame(1, 4'b1111, 4'b1111, 2, 48'hCCCC_BBBB_AAAA, 0, -1);
    do_frame(2, 4'b0101, 4'b1111, 2, 48'h0123_4567_89AB, -1, -1);
    do_frame(3, 4'b0101, 4'b0101, 2, 48'h1111_2222_3333, 24, -1);
    do_frame(4, 4'b1111, 4'b0000, 1, 48'hDEAD_BEEF_CAFE, -1, -1);
    do_frame(5, 4'b1111, 4'b1111, 1, 48'h5555_6666_7777, -1, 0);
    do_frame(6, 4'b0000, 4'b1111, 1, 48'h0F0F_F0F0_AA55, -1, -1);

    // Reset on the first TS cycle of a frame
    raddr_A = AW'(exp_waddr); ch_en = 4'b0001; nrx_samps = 8'd1;
    ticks_A = 48'h3333_2222_1111;
    load_din(7, 0);
    fd0 = fd_cnt;
    @(negedge adc_clk); rx_avail_A = 1'b1;
    @(negedge adc_clk); rx_avail_A = 1'b0;
    k = 0;
    while (!(wr_A && wdata_A == 16'h1111) && k < 50) begin
      @(negedge adc_clk);
      k++;
    end
    check("ts_reached", 64'(wdata_A), 64'h1111);
    reset_A = 1'b1;
    #1;
    check("arst_wr", 64'(wr_A), 64'd0);
    check("arst_waddr", 64'(waddr_A), 64'd0);
    check("arst_busy", 64'(busy_A), 64'd0);
    check("arst_ctr", 64'(buf_ctr_A), 64'd0);
    check("arst_drop", 64'(drop_cnt_A), 64'd0);
    check("arst_ovr", 64'(ovr_cnt_A), 64'd0);
    repeat (3) @(negedge adc_clk);
    #1;
    check("arst_no_done", 64'(fd_cnt - fd0), 64'd0);
    reset_A = 1'b0;
    exp_waddr = 0; exp_ctr = 0; exp_drop = 0; exp_ovr = 0;
    $display("reset mid-frame applied, counters cleared");

    do_frame(8, 4'b0001, 4'b1111, 1, 48'h0000_0000_0042, 0, -1);
    do_frame(9, 4'b0001, 4'b0001, 0, 48'h1234_5678_9ABC, -1, -1);
    do_frame(10, 4'b0011, 4'b0011, 2, 48'hFEDC_BA98_7654, -1, -1);
    check("wrap_start", 64'(waddr_A), 64'(DEPTH - 2));
    do_frame(11, 4'b1111, 4'b1111, 1, 48'hABCD_0000_FFFF, -1, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
